// File: rtl/tnoc_vc_input_buffer.sv
// tnoc_vc_input_buffer: per-VC FWFT flit FIFOs behind a shared-bus valid/ready port.
module tnoc_vc_input_buffer #(
  parameter int CHANNELS            = 2,
  parameter int DEPTH               = 4,
  parameter int FLIT_WIDTH          = 64,
  parameter int AVAILABLE_THRESHOLD = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS-1:0]            i_valid,
  output logic [CHANNELS-1:0]            o_ready,
  input  logic [FLIT_WIDTH-1:0]          i_flit,
  output logic [CHANNELS-1:0]            o_vc_available,
  output logic [CHANNELS-1:0]            o_valid,
  input  logic [CHANNELS-1:0]            i_ready,
  output logic [CHANNELS*FLIT_WIDTH-1:0] o_flit,
  output logic                           o_protocol_error
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [CHANNELS-1:0] w_not_full, w_first, w_push, w_pop;
  logic                r_error;
  // Isolate the lowest asserted i_valid bit; only that channel may be accepted.
  assign w_first          = i_valid & (~i_valid + CHANNELS'(1));
  assign o_ready          = w_not_full & (w_first | ~i_valid);
  assign w_push           = i_valid & o_ready;
  assign w_pop            = o_valid & i_ready;
  assign o_protocol_error = r_error;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_error <= 1'b0;
    else        r_error <= r_error | ((i_valid & (i_valid - CHANNELS'(1))) != '0);
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;
    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wptr] <= i_flit;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + PW'(1);
        if (w_pop[g])  r_rptr <= r_rptr + PW'(1);
        r_count <= r_count + CW'(w_push[g]) - CW'(w_pop[g]);
      end
    end
    assign w_not_full[g]     = r_count != CW'(DEPTH);
    assign o_valid[g]        = r_count != '0;
    assign o_vc_available[g] = (CW'(DEPTH) - r_count) >= CW'(AVAILABLE_THRESHOLD);
    assign o_flit[g*FLIT_WIDTH +: FLIT_WIDTH] = r_mem[r_rptr];
  end
endmodule

// File: tb/tb_tnoc_vc_input_buffer.sv
// tb_tnoc_vc_input_buffer: directed and random checks against a queue-based model.
module tb_tnoc_vc_input_buffer;
  localparam int CH = 2;
  localparam int D  = 4;
  localparam int FW = 64;
  localparam int TH = 2;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [CH-1:0]    i_valid, o_ready, o_vc_available, o_valid, i_ready;
  logic [FW-1:0]    i_flit;
  logic [CH*FW-1:0] o_flit;
  logic             o_protocol_error;
  int               n_checks = 0;
  int               n_fail = 0;
  logic [FW-1:0]    q [CH][$];
  logic             m_err;

  tnoc_vc_input_buffer #(.CHANNELS(CH), .DEPTH(D), .FLIT_WIDTH(FW), .AVAILABLE_THRESHOLD(TH)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_flit(i_flit),
    .o_vc_available(o_vc_available), .o_valid(o_valid), .i_ready(i_ready), .o_flit(o_flit),
    .o_protocol_error(o_protocol_error)
  );

  always #5 clk = ~clk;

  function automatic logic [CH-1:0] exp_ready(input logic [CH-1:0] v);
    int low = -1;
    logic [CH-1:0] r;
    for (int c = CH - 1; c >= 0; c--) if (v[c]) low = c;
    for (int c = 0; c < CH; c++) r[c] = (q[c].size() != D) && (!v[c] || c == low);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_valid();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = q[c].size() != 0;
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_avail();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = (D - q[c].size()) >= TH;
    return r;
  endfunction

  function automatic logic [FW-1:0] slice(input int c);
    return o_flit[c*FW +: FW];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) q[c].delete();
    m_err = 1'b0;
  endtask

  task automatic drive(input logic [CH-1:0] v, input logic [FW-1:0] f, input logic [CH-1:0] r);
    i_valid = v;
    i_flit  = f;
    i_ready = r;
    #1;
  endtask

  // Advance one clock edge, applying the handshake rules to the model queues.
  task automatic step();
    logic [CH-1:0] pu, po;
    logic [FW-1:0] f;
    pu = i_valid & exp_ready(i_valid);
    po = exp_valid() & i_ready;
    f  = i_flit;
    if ($countones(i_valid) > 1) m_err = 1'b1;
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      if (po[c]) void'(q[c].pop_front());
      if (pu[c]) q[c].push_back(f);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive('0, '0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 2'b11 || o_vc_available !== 2'b11 || o_valid !== 2'b00 || o_protocol_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ready=%b avail=%b valid=%b err=%b, want 11 11 00 0",
               o_ready, o_vc_available, o_valid, o_protocol_error);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 64'hA0 + FW'(k), 2'b00);
      n_checks++;
      if (o_ready[0] !== (k < 4) || o_ready[1] !== 1'b1 || o_ready !== exp_ready(i_valid)) begin
        n_fail++;
        $display("FAIL fill_ready k=%0d: got %b want %b", k, o_ready, exp_ready(i_valid));
      end
      n_checks++;
      if (o_vc_available[0] !== (k < 3) || o_vc_available !== exp_avail()) begin
        n_fail++;
        $display("FAIL fill_avail k=%0d: got %b want %b", k, o_vc_available, exp_avail());
      end
      step();
    end
    n_checks++;
    if (q[0].size() != D || o_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL fill_done: valid=%b want 01, model size %0d", o_valid, q[0].size());
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, '0, 2'b01);
      n_checks++;
      if (o_valid[0] !== 1'b1 || slice(0) !== 64'hA0 + FW'(k) || slice(0) !== q[0][0]) begin
        n_fail++;
        $display("FAIL drain k=%0d: valid=%b flit=%h want %h", k, o_valid[0], slice(0), 64'hA0 + FW'(k));
      end
      step();
    end
    drive(2'b00, '0, 2'b00);
    n_checks++;
    if (o_valid !== 2'b00 || o_vc_available !== 2'b11 || o_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%b avail=%b ready=%b want 00 11 11", o_valid, o_vc_available, o_ready);
    end
  endtask

  task automatic test_push_pop();
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 64'hB3 + FW'(k), 2'b00);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      drive(2'b10, 64'hB5 + FW'(k), 2'b10);
      n_checks++;
      if (o_valid[1] !== 1'b1 || slice(1) !== q[1][0] || slice(1) !== 64'hB3 + FW'(k)
          || o_vc_available[1] !== 1'b1 || o_ready[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL push_pop k=%0d: flit=%h want %h avail=%b ready=%b", k, slice(1), 64'hB3 + FW'(k),
                 o_vc_available[1], o_ready[1]);
      end
      step();
    end
    n_checks++;
    if (q[1].size() != 2 || o_vc_available[1] !== 1'b1 || slice(1) !== 64'hB9) begin
      n_fail++;
      $display("FAIL push_pop_end: flit=%h want b9 avail=%b", slice(1), o_vc_available[1]);
    end
    for (int k = 0; k < 2; k++) begin
      drive(2'b00, '0, 2'b10);
      step();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(CH'($urandom_range(0, 2)) == 2 ? 2'b10 : CH'($urandom_range(0, 1)),
            {$urandom, $urandom}, CH'($urandom));
      n_checks++;
      if (o_ready !== exp_ready(i_valid) || o_valid !== exp_valid() || o_vc_available !== exp_avail()) begin
        n_fail++;
        $display("FAIL rand_ctl n=%0d: ready=%b/%b valid=%b/%b avail=%b/%b", n, o_ready, exp_ready(i_valid),
                 o_valid, exp_valid(), o_vc_available, exp_avail());
      end
      for (int c = 0; c < CH; c++) if (q[c].size() != 0) begin
        n_checks++;
        if (slice(c) !== q[c][0]) begin
          n_fail++;
          $display("FAIL rand_flit n=%0d ch=%0d: got %h want %h", n, c, slice(c), q[c][0]);
        end
      end
      step();
    end
    while (exp_valid() != '0) begin
      drive('0, '0, '1);
      step();
    end
  endtask

  task automatic test_multi_valid();
    drive(2'b11, 64'hC0, 2'b00);
    n_checks++;
    if (o_ready !== 2'b01 || o_protocol_error !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_cycle: ready=%b err=%b want 01 0", o_ready, o_protocol_error);
    end
    step();
    drive(2'b00, '0, 2'b00);
    n_checks++;
    if (o_protocol_error !== 1'b1 || o_valid !== 2'b01 || slice(0) !== 64'hC0 || q[1].size() != 0) begin
      n_fail++;
      $display("FAIL multi_store: err=%b valid=%b flit0=%h want 1 01 c0", o_protocol_error, o_valid, slice(0));
    end
    repeat (3) begin
      drive(2'b01, 64'hC1, 2'b01);
      step();
    end
    n_checks++;
    if (o_protocol_error !== m_err || m_err !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_sticky: err=%b want 1", o_protocol_error);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, 64'hD0 + FW'(k), 2'b00);
      step();
    end
    drive(2'b00, '0, 2'b00);
    n_checks++;
    if (o_valid !== 2'b01 || slice(0) !== q[0][0]) begin
      n_fail++;
      $display("FAIL async_pre: valid=%b flit=%h want 01 %h", o_valid, slice(0), q[0][0]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (o_valid !== 2'b00 || o_ready !== 2'b11 || o_protocol_error !== 1'b0 || o_vc_available !== 2'b11) begin
      n_fail++;
      $display("FAIL async_imm: valid=%b ready=%b err=%b avail=%b want 00 11 0 11",
               o_valid, o_ready, o_protocol_error, o_vc_available);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, '0, 2'b11);
      n_checks++;
      if (o_valid !== 2'b00 || o_protocol_error !== 1'b0) begin
        n_fail++;
        $display("FAIL async_stale k=%0d: valid=%b err=%b want 00 0", k, o_valid, o_protocol_error);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_push_pop();
    test_random();
    test_multi_valid();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
